// File: rtl/mc_ctrl_pkg.sv
// Purpose : shared types and constants for the multicycle ARM control unit.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum, ALU operation codes, DP opcode (Funct[4:1]) codes,
//           mux-select encodings and the DP opcode decode helper.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  // ALU operation codes (full 3-bit encoding; narrower ALUs take the low bits)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;

  // Data-processing opcodes, Funct[4:1]
  localparam logic [3:0] FN_AND = 4'b0000;
  localparam logic [3:0] FN_EOR = 4'b0001;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_ADD = 4'b0100;
  localparam logic [3:0] FN_TST = 4'b1000;
  localparam logic [3:0] FN_CMP = 4'b1010;
  localparam logic [3:0] FN_CMN = 4'b1011;
  localparam logic [3:0] FN_ORR = 4'b1100;
  localparam logic [3:0] FN_MOV = 4'b1101;

  // Instruction classes, Op = instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  // Mux selects
  localparam logic       ADR_PC        = 1'b0;
  localparam logic       ADR_ALUOUT    = 1'b1;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic       SRCA_RD1      = 1'b0;
  localparam logic       SRCA_PC       = 1'b1;
  localparam logic [1:0] SRCB_RD2      = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;

  typedef struct packed {
    logic [2:0] code;   // ALU operation
    logic       cmp;    // compare class: flags only, no register writeback
    logic       arith;  // ADD/SUB class: C and V are meaningful
    logic       valid;  // opcode supported by this build
  } alu_dec_t;

  // Unsupported opcodes decode as ADD with valid=0 so the datapath never sees
  // an undefined ALU code; ext_ok enables the EOR/MOV extension.
  function automatic alu_dec_t alu_decode(input logic [3:0] fn, input logic ext_ok);
    alu_dec_t d;
    d = '{code: ALU_ADD, cmp: 1'b0, arith: 1'b0, valid: 1'b1};
    case (fn)
      FN_ADD: d.arith = 1'b1;
      FN_SUB: begin d.code = ALU_SUB; d.arith = 1'b1; end
      FN_AND: d.code = ALU_AND;
      FN_ORR: d.code = ALU_ORR;
      FN_EOR: if (ext_ok) d.code = ALU_EOR; else d.valid = 1'b0;
      FN_MOV: if (ext_ok) d.code = ALU_MOV; else d.valid = 1'b0;
      FN_CMP: begin d.code = ALU_SUB; d.cmp = 1'b1; d.arith = 1'b1; end
      FN_TST: begin d.code = ALU_AND; d.cmp = 1'b1; end
      FN_CMN: begin d.code = ALU_ADD; d.cmp = 1'b1; d.arith = 1'b1; end
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm.sv
// Purpose : main control FSM of the multicycle datapath (state register,
//           next-state logic, per-state mux selects and write strobes).
// Latency : one state per clock; memory states hold while mem_ready_i=0.
// Ports   : clk/reset (async active-low); op_i, is_imm_i (Funct[5]),
//           is_load_i (Funct[0]), mem_ready_i, dp_nowb_i (skip ALU writeback)
//           in; state_o, strobes and mux selects out.
module mc_ctrl_fsm #(
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op_i,
  input  logic       is_imm_i,
  input  logic       is_load_i,
  input  logic       mem_ready_i,
  input  logic       dp_nowb_i,
  output logic [3:0] state_o,
  output logic       irwrite_o,
  output logic       nextpc_o,
  output logic       regw_o,
  output logic       memw_o,
  output logic       branch_o,
  output logic       aluop_o,
  output logic       adrsrc_o,
  output logic [1:0] resultsrc_o,
  output logic       alusrca_o,
  output logic [1:0] alusrcb_o
);
  import mc_ctrl_pkg::*;

  state_e state_q, state_d;
  logic   mem_ok;

  // Without the handshake every memory access completes in one cycle.
  assign mem_ok = (MEM_HANDSHAKE != 0) ? mem_ready_i : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_i)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = is_imm_i ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = is_load_i ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ok ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ok ? S_FETCH : S_MEMWRITE;
      S_EXECUTER,
      S_EXECUTEI: state_d = dp_nowb_i ? S_FETCH : S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    irwrite_o   = 1'b0;
    nextpc_o    = 1'b0;
    regw_o      = 1'b0;
    memw_o      = 1'b0;
    branch_o    = 1'b0;
    aluop_o     = 1'b0;
    adrsrc_o    = ADR_PC;
    resultsrc_o = RES_ALUOUT;
    alusrca_o   = SRCA_RD1;
    alusrcb_o   = SRCB_RD2;
    case (state_q)
      S_FETCH: begin
        // Reset parks the FSM in FETCH; the IR/PC loads must stay off until
        // reset is released, hence the direct reset qualification.
        irwrite_o   = reset & mem_ok;
        nextpc_o    = reset & mem_ok;
        adrsrc_o    = ADR_PC;
        alusrca_o   = SRCA_PC;
        alusrcb_o   = SRCB_FOUR;
        resultsrc_o = RES_ALURESULT;
      end
      S_DECODE: begin
        alusrca_o   = SRCA_PC;
        alusrcb_o   = SRCB_FOUR;
        resultsrc_o = RES_ALURESULT;
      end
      S_MEMADR: begin
        alusrca_o = SRCA_RD1;
        alusrcb_o = SRCB_IMM;
      end
      S_MEMREAD: begin
        adrsrc_o    = ADR_ALUOUT;
        resultsrc_o = RES_ALUOUT;
      end
      S_MEMWB: begin
        resultsrc_o = RES_DATA;
        regw_o      = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc_o    = ADR_ALUOUT;
        resultsrc_o = RES_ALUOUT;
        memw_o      = 1'b1;
      end
      S_EXECUTER: begin
        alusrca_o = SRCA_RD1;
        alusrcb_o = SRCB_RD2;
        aluop_o   = 1'b1;
      end
      S_EXECUTEI: begin
        alusrca_o = SRCA_RD1;
        alusrcb_o = SRCB_IMM;
        aluop_o   = 1'b1;
      end
      S_ALUWB: begin
        resultsrc_o = RES_ALUOUT;
        regw_o      = 1'b1;
      end
      S_BRANCH: begin
        alusrca_o   = SRCA_RD1;
        alusrcb_o   = SRCB_IMM;
        resultsrc_o = RES_ALURESULT;
        branch_o    = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/mc_decode_gen.sv
// Purpose : decoder/control unit for the multicycle ARM datapath: FSM plus
//           ALU decoder, flag-write, PCS, RegSrc and ImmSrc logic.
// Latency : strobes are combinational from the current state and IR fields.
// Ports   : clk, reset (async active-low), Op/Funct/Rd from the IR, MemReady;
//           FlagW, PCS, NextPC, RegW, MemW, IRWrite, mux selects, ALUControl,
//           Undef and State (debug) out.
module mc_decode_gen #(
  parameter int ALUCTRL_W     = 3,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic                 MemReady,
  output logic [1:0]           FlagW,
  output logic                 PCS,
  output logic                 NextPC,
  output logic                 RegW,
  output logic                 MemW,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Undef,
  output logic [3:0]           State
);
  import mc_ctrl_pkg::*;

  alu_dec_t   dec;
  logic       dp_nowb;
  logic       regw, branch, aluop;
  logic       flag_nz;
  logic [2:0] alu_code;
  logic [3:0] state;

  assign dec = alu_decode(Funct[4:1], ALUCTRL_W >= 3);

  // Compares and unsupported opcodes both return straight to FETCH.
  assign dp_nowb = dec.cmp | ~dec.valid;

  mc_ctrl_fsm #(
    .MEM_HANDSHAKE(MEM_HANDSHAKE)
  ) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .op_i        (Op),
    .is_imm_i    (Funct[5]),
    .is_load_i   (Funct[0]),
    .mem_ready_i (MemReady),
    .dp_nowb_i   (dp_nowb),
    .state_o     (state),
    .irwrite_o   (IRWrite),
    .nextpc_o    (NextPC),
    .regw_o      (regw),
    .memw_o      (MemW),
    .branch_o    (branch),
    .aluop_o     (aluop),
    .adrsrc_o    (AdrSrc),
    .resultsrc_o (ResultSrc),
    .alusrca_o   (ALUSrcA),
    .alusrcb_o   (ALUSrcB)
  );

  assign alu_code   = aluop ? dec.code : ALU_ADD;
  assign ALUControl = alu_code[ALUCTRL_W-1:0];

  // An undefined opcode must not disturb the flags even if its S bit is set.
  assign flag_nz = aluop & dec.valid & (Funct[0] | dec.cmp);
  assign FlagW   = {flag_nz, flag_nz & dec.arith};

  assign RegW  = regw;
  assign PCS   = ((Rd == 4'd15) & regw) | branch;
  assign Undef = (state == S_DECODE) &
                 ((Op == OP_UND) | ((Op == OP_DP) & ~dec.valid));
  assign ImmSrc = Op;
  assign State  = state;

  always_comb begin
    RegSrc = 2'b00;
    case (Op)
      OP_MEM:  RegSrc = Funct[0] ? 2'b00 : 2'b10;  // store reads Rd as RD2
      OP_BR:   RegSrc = 2'b01;                     // branch reads PC as RD1
      default: RegSrc = 2'b00;
    endcase
  end

endmodule

// File: doc/mc_decode_gen.md
Name: mc_decode_gen

Overview:
- Parametrised next-generation decoder/control unit for the multicycle ARM datapath.
- Holds the main control FSM: fetch, decode, memory, execute, ALU writeback and branch.
- Adds four things to the current decoder:
  - Configurable ALU-control width.
  - Extended DP ops: EOR, MOV, and the compare ops CMP/TST/CMN, which set flags without writeback.
  - Memory ready/wait handshake.
  - Undefined-instruction flag.
- Sits between the instruction register and the datapath; drives every mux select and write strobe.

Parameters:
- ALUCTRL_W, 3: ALUControl width. 2 supports ADD/SUB/AND/ORR only; 3 adds EOR and MOV.
- MEM_HANDSHAKE, 1: 1 = FSM waits on MemReady in memory states; 0 = MemReady ignored and treated as 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- Op  in  2  instr[27:26].
- Funct  in  6  instr[25:20].
- Rd  in  4  instr[15:12].
- MemReady  in  1  memory access completes this cycle.
- FlagW  out  2  [1]=NZ write, [0]=CV write.
- PCS  out  1  PC written from result.
- NextPC  out  1  PC increment strobe.
- RegW  out  1  register file write.
- MemW  out  1  data memory write.
- IRWrite  out  1  instruction register load.
- AdrSrc  out  1  0=PC, 1=ALUOut.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  1  0=RD1, 1=PC.
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=const 4.
- ImmSrc  out  2  equals Op.
- RegSrc  out  2  register-address selects.
- ALUControl  out  ALUCTRL_W  ALU operation.
- Undef  out  1  high in DECODE when instruction unsupported.
- State  out  4  current FSM state (debug).

Behaviour:
- Reset (reset=0, any time, including mid-instruction):
  - State=FETCH immediately.
  - IRWrite, NextPC, RegW, MemW, PCS, FlagW, Undef all forced 0.
  - First FETCH action occurs on the first edge after release.
- FSM states and transitions:
  - FETCH -> DECODE when MemReady.
  - DECODE -> MEMADR if Op=01; EXECUTER if Op=00 & !Funct[5]; EXECUTEI if Op=00 & Funct[5]; BRANCH if Op=10; FETCH if Op=11 (Undef=1).
  - MEMADR -> MEMREAD if Funct[0], else MEMWRITE.
  - MEMREAD -> MEMWB when MemReady.
  - MEMWRITE -> FETCH when MemReady.
  - EXECUTER/EXECUTEI -> ALUWB, or -> FETCH if compare op.
  - MEMWB, ALUWB, BRANCH -> FETCH.
- Wait rule: memory states hold while MemReady=0. AdrSrc/ResultSrc stay stable during the wait. IRWrite and NextPC assert only in the FETCH cycle where MemReady=1. MemW stays asserted throughout MEMWRITE.
- Outputs per state (unlisted strobes = 0):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode (ALUOp=1), keyed on Funct[4:1]:
  - 0100 ADD=000.
  - 0010 SUB=001.
  - 0000 AND=010.
  - 1100 ORR=011.
  - 0001 EOR=100.
  - 1101 MOV=101.
  - 1010 CMP=SUB, no writeback.
  - 1000 TST=AND, no writeback.
  - 1011 CMN=ADD, no writeback.
- Width and undefined ops:
  - With ALUCTRL_W=2, EOR and MOV are unsupported.
  - Unsupported codes: ALUControl=ADD, Undef=1 in DECODE, FSM skips ALUWB and returns to FETCH.
  - ALUOp=0: ALUControl=ADD, FlagW=00.
- FlagW:
  - [1] = S bit, or 1 for compare ops.
  - [0] = FlagW[1] & (ADD or SUB class).
- PCS = (Rd==15 & RegW) | Branch.
- RegSrc:
  - Op=00: 00.
  - Op=01: Funct[0] ? 00 : 10.
  - Op=10: 01.
  - Op=11: 00.
- No X outputs in any state.

Decomposition:
- Package mc_ctrl_pkg holds:
  - State enum (4-bit).
  - ALU code constants (ALU_ADD..ALU_MOV).
  - Funct[4:1] opcode constants.
  - Mux-select constants.
- Sub-module mc_ctrl_fsm holds the state register, next-state logic and per-state strobes, including the wait handling.
- mc_decode_gen keeps the ALU decoder, flag logic, PCS, RegSrc and ImmSrc.

Test Plan:
- Reset pulse during MEMREAD with MemReady=0: State=FETCH while reset=0; all strobes 0; after release, IRWrite=1 on the first cycle with MemReady=1.
- LDR (Op=01, Funct=011001), MemReady low 3 cycles in MEMREAD: state sequence FETCH, DECODE, MEMADR, MEMREAD×4, MEMWB. RegW=1 only in MEMWB; AdrSrc=1 held throughout the wait.
- EOR register form with S (Funct=000011), ALUCTRL_W=3: ALUControl=100 in EXECUTER; FlagW=10; ALUWB RegW=1. Same instruction with ALUCTRL_W=2: Undef=1 and no RegW.
- CMP immediate (Funct=110101): ALUControl=001, FlagW=11. EXECUTEI goes directly to FETCH; RegW never asserted.
- ADD with Rd=15: PCS=1 in ALUWB. B (Op=10): PCS=1 in BRANCH; ALUSrcB=01.
- MEM_HANDSHAKE=0, MemReady tied to 0: STR completes as FETCH, DECODE, MEMADR, MEMWRITE (MemW=1 for one cycle), FETCH.
